pixel_tx: RTL and testbench

Pixel-stream transmitter for the pixel port of the DSP front end. It buffers bytes written by the host in a small FIFO. Once a full burst is buffered, it raises `pix_req`, waits for `pix_ack`, then emits the burst one byte per cycle. Each byte is pre-scrambled with 8'hCC so the receiver's XOR descrambler recovers the original data.

---
 rtl/pixel_tx.sv | 136 +++++++++++++
 tb/tb_pixel_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_tx.sv
// rtl/pixel_tx.sv - burst pixel transmitter: host byte FIFO, req/ack handshake, scrambled byte stream
module pixel_tx #(
  parameter int AW         = 3,
  parameter int BURST      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          pix_req,
  input  logic          pix_ack,
  output logic [7:0]    pixel_out,
  output logic          pixel_valid,
  output logic          burst_done,
  output logic          busy
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_C  = (AW+1)'(BURST);
  localparam logic [3:0]  GAP_C    = 4'(GAP_CYCLES);
  localparam logic [7:0]  SCRAMBLE = 8'hCC;

  typedef enum logic [1:0] {IDLE, REQ, SEND, GAP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   beat;
  logic [3:0]    gap_cnt;
  logic          wr_acc;
  logic          pop;

  // full is judged on the registered occupancy, so a pop in the same cycle never frees a slot early
  assign full   = (count == DEPTH_C);
  assign wr_acc = wr_en && !full;
  // beat == BURST is the extra SEND cycle that emits burst_done without popping
  assign pop    = (state == SEND) && (beat != BURST_C);
  assign busy   = (state != IDLE);

  // FIFO storage; contents need no reset since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Burst FSM with registered handshake and stream outputs
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state       <= IDLE;
      pix_req     <= 1'b0;
      pixel_out   <= 8'h00;
      pixel_valid <= 1'b0;
      burst_done  <= 1'b0;
      beat        <= '0;
      gap_cnt     <= '0;
    end else begin
      burst_done  <= 1'b0;
      pixel_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en && (count >= BURST_C)) begin
            state   <= REQ;
            pix_req <= 1'b1;
          end
        end
        REQ: begin
          // ack has priority over a simultaneous enable drop
          if (pix_ack) begin
            state <= SEND;
            beat  <= '0;
          end else if (!en) begin
            state   <= IDLE;
            pix_req <= 1'b0;
          end
        end
        SEND: begin
          // pix_req stays up through the ack cycle and falls with the first beat
          pix_req <= 1'b0;
          if (beat != BURST_C) begin
            pixel_out   <= mem[rd_ptr] ^ SCRAMBLE;
            pixel_valid <= 1'b1;
            beat        <= beat + 1'b1;
          end else begin
            burst_done <= 1'b1;
            state      <= GAP;
            gap_cnt    <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_C) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_tx.sv
// tb/tb_pixel_tx.sv - table-driven and directed-sequence bench for pixel_tx
module tb_pixel_tx;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [3:0] count;
  logic       overflow;
  logic       pix_req;
  logic       pix_ack;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       burst_done;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  pixel_tx #(.AW(3), .BURST(4), .GAP_CYCLES(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .pix_req     (pix_req),
    .pix_ack     (pix_ack),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .burst_done  (burst_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       en;
    logic       ack;
    logic [3:0] e_count;
    logic       e_full;
    logic       e_req;
    logic       e_valid;
    logic [7:0] e_pix;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(logic w, logic [7:0] d, logic e, logic a, logic [3:0] c,
                              logic f, logic r, logic vl, logic [7:0] p, logic dn, logic b);
    vec_t x;
    x.wr_en = w; x.wr_data = d; x.en = e; x.ack = a;
    x.e_count = c; x.e_full = f; x.e_req = r; x.e_valid = vl;
    x.e_pix = p; x.e_done = dn; x.e_busy = b;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 20 && !pix_req; k++) begin
      @(posedge clk);
      #1;
    end
    check(name, pix_req, 1);
  endtask

  // Grant one request, then expect BURST beats first..first+3 (scrambled) and a done pulse
  task automatic expect_burst(input string name, input logic [7:0] first);
    wait_req({name, "_req"});
    @(negedge clk);
    pix_ack = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_req_held"}, pix_req, 1);
    @(negedge clk);
    pix_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_valid%0d", name, b), pixel_valid, 1);
      check($sformatf("%s_pix%0d", name, b), pixel_out, (first + 8'(b)) ^ 8'hCC);
    end
    @(posedge clk);
    #1;
    check({name, "_done"}, burst_done, 1);
    check({name, "_valid_end"}, pixel_valid, 0);
  endtask

  initial begin
    logic [7:0] got [$];
    int         d_cyc;
    int         r_cyc;

    rstn    = 1'b1;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    pix_ack = 1'b0;

    // single burst 00,11,22,33; ack one cycle after pix_req
    vt[0]  = mk(1, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    vt[1]  = mk(1, 8'h11, 1, 0, 2, 0, 0, 0, 8'h00, 0, 0);
    vt[2]  = mk(1, 8'h22, 1, 0, 3, 0, 0, 0, 8'h00, 0, 0);
    vt[3]  = mk(1, 8'h33, 1, 0, 4, 0, 0, 0, 8'h00, 0, 0);
    vt[4]  = mk(0, 8'h00, 1, 0, 4, 0, 1, 0, 8'h00, 0, 1);
    vt[5]  = mk(0, 8'h00, 1, 1, 4, 0, 1, 0, 8'h00, 0, 1);
    vt[6]  = mk(0, 8'h00, 1, 0, 3, 0, 0, 1, 8'hCC, 0, 1);
    vt[7]  = mk(0, 8'h00, 1, 0, 2, 0, 0, 1, 8'hDD, 0, 1);
    vt[8]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hEE, 0, 1);
    vt[9]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hFF, 0, 1);
    vt[10] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'hFF, 1, 1);
    vt[11] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'hFF, 0, 1);
    vt[12] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'hFF, 0, 1);
    vt[13] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'hFF, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_req", pix_req, 0);
    check("rst_valid", pixel_valid, 0);
    check("rst_pix", pixel_out, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rstn = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wr_en   = vt[i].wr_en;
      wr_data = vt[i].wr_data;
      en      = vt[i].en;
      pix_ack = vt[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), count, vt[i].e_count);
      check($sformatf("v%0d_full", i), full, vt[i].e_full);
      check($sformatf("v%0d_req", i), pix_req, vt[i].e_req);
      check($sformatf("v%0d_valid", i), pixel_valid, vt[i].e_valid);
      check($sformatf("v%0d_pix", i), pixel_out, vt[i].e_pix);
      check($sformatf("v%0d_done", i), burst_done, vt[i].e_done);
      check($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      check($sformatf("v%0d_ovf", i), overflow, 0);
    end
    @(negedge clk);
    wr_en   = 1'b0;
    en      = 1'b0;
    pix_ack = 1'b0;

    // full / overflow: 9 back-to-back writes with requests disabled
    for (int i = 0; i < 9; i++) begin
      write_byte(8'hA0 + 8'(i));
      if (i == 7) begin
        check("ovf_full_at8", full, 1);
        check("ovf_no_ovf_at8", overflow, 0);
      end
    end
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    @(posedge clk);
    #1;
    check("ovf_sticky", overflow, 1);

    // asynchronous reset in the middle of a burst
    @(negedge clk);
    en = 1'b1;
    wait_req("mid_req");
    @(negedge clk);
    pix_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pix_ack = 1'b0;
    @(posedge clk);
    #1;
    check("mid_valid", pixel_valid, 1);
    check("mid_pix", pixel_out, 8'hA0 ^ 8'hCC);
    #1;
    rstn = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_pix", pixel_out, 8'h00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_full", full, 0);
    @(negedge clk);
    rstn = 1'b0;
    en   = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_count", count, 0);
    check("post_rst_req", pix_req, 0);

    // request abort: drop en before ack
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("abort_req_up", pix_req, 1);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_req_down", pix_req, 0);
    check("abort_busy", busy, 0);
    check("abort_count", count, 4);

    // pointer wrap with writes during SEND
    write_byte(8'd5);
    write_byte(8'd6);
    check("wrap_prefill", count, 6);
    @(negedge clk);
    en = 1'b1;
    wait_req("wrap_req");
    @(negedge clk);
    pix_ack = 1'b1;
    @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      pix_ack = 1'b0;
      wr_en   = 1'b1;
      wr_data = 8'd7 + 8'(b);
      @(posedge clk);
      #1;
      check($sformatf("wrap_valid%0d", b), pixel_valid, 1);
      check($sformatf("wrap_pix%0d", b), pixel_out, (8'd1 + 8'(b)) ^ 8'hCC);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_done", burst_done, 1);
    check("wrap_count", count, 6);
    expect_burst("wrap2", 8'd5);

    // gap spacing with ack held high over two bursts
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    check("gap_idle", busy, 0);
    for (int i = 11; i <= 16; i++) write_byte(8'(i));
    check("gap_count8", count, 8);
    check("gap_full", full, 1);
    @(negedge clk);
    en      = 1'b1;
    pix_ack = 1'b1;
    d_cyc = -1;
    r_cyc = -1;
    for (int c = 0; c < 60 && r_cyc < 0; c++) begin
      @(posedge clk);
      #1;
      if (pixel_valid) got.push_back(pixel_out);
      if (burst_done && d_cyc < 0) d_cyc = c;
      if (pix_req && d_cyc >= 0 && r_cyc < 0) r_cyc = c;
    end
    check("gap_done_seen", (d_cyc >= 0), 1);
    check("gap_req_seen", (r_cyc >= 0), 1);
    check("gap_spacing", r_cyc - d_cyc, 4);
    for (int c = 0; c < 60 && got.size() < 8; c++) begin
      @(posedge clk);
      #1;
      if (pixel_valid) got.push_back(pixel_out);
    end
    check("gap_beats", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      check($sformatf("gap_pix%0d", i), got[i], (8'd9 + 8'(i)) ^ 8'hCC);
    end
    @(negedge clk);
    pix_ack = 1'b0;
    en      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("gap_final_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
